// File: rtl/distance_smoother.sv
// Clamp, 2^AVG_LOG2-tap moving average and registered output for raw distance samples.
// Optional slew limiting of the output is enabled by defining SMOOTH_SLEW_LIMIT_EN.
module distance_smoother #(
    parameter int WIDTH     = 13,
    parameter int AVG_LOG2  = 4,
    parameter int MAX_DIST  = 2000,
    parameter int SLEW_STEP = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample_in,
    output logic [WIDTH-1:0] distance_out,
    output logic             distance_valid
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = WIDTH + AVG_LOG2;
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_DIST);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH + 1)'(SLEW_STEP);

`ifdef SMOOTH_SLEW_LIMIT_EN
    localparam bit SLEW_EN = 1'b1;
`else
    localparam bit SLEW_EN = 1'b0;
`endif

    typedef enum logic {
        EMPTY,
        RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] buf_mem [DEPTH];
    logic [SUM_W-1:0] sum;
    logic [AVG_LOG2-1:0] wr_ptr;
    logic             s1_valid;
    logic             s1_prime;

    logic [WIDTH-1:0] clamped;
    logic [WIDTH-1:0] avg;
    logic [WIDTH-1:0] slewed;
    logic [WIDTH-1:0] next_out;
    logic [WIDTH:0]   out_x;
    logic [WIDTH:0]   avg_x;

    // Slew comparisons use one extra bit so out+STEP and avg+STEP cannot wrap.
    always_comb begin
        clamped = (sample_in > MAX_W) ? MAX_W : sample_in;
        avg     = sum[SUM_W-1:AVG_LOG2];
        out_x   = {1'b0, distance_out};
        avg_x   = {1'b0, avg};
        slewed  = avg;
        if (avg_x > out_x + STEP_X) begin
            slewed = distance_out + STEP_X[WIDTH-1:0];
        end else if (avg_x + STEP_X < out_x) begin
            slewed = distance_out - STEP_X[WIDTH-1:0];
        end
        next_out = (SLEW_EN && !s1_prime) ? slewed : avg;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= EMPTY;
            for (int i = 0; i < DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
            sum            <= '0;
            wr_ptr         <= '0;
            s1_valid       <= 1'b0;
            s1_prime       <= 1'b0;
            distance_out   <= '0;
            distance_valid <= 1'b0;
        end else begin
            distance_valid <= 1'b0;
            if (enable) begin
                if (clear) begin
                    // Clear drops any incoming sample and squashes the one in stage 1.
                    state    <= EMPTY;
                    s1_valid <= 1'b0;
                end else begin
                    s1_valid <= sample_valid;
                    if (s1_valid) begin
                        distance_out   <= next_out;
                        distance_valid <= 1'b1;
                    end
                    if (sample_valid) begin
                        s1_prime <= (state == EMPTY);
                        if (state == EMPTY) begin
                            for (int i = 0; i < DEPTH; i++) begin
                                buf_mem[i] <= clamped;
                            end
                            sum    <= SUM_W'(clamped) << AVG_LOG2;
                            wr_ptr <= AVG_LOG2'(1);
                            state  <= RUN;
                        end else begin
                            sum             <= sum + SUM_W'(clamped) - SUM_W'(buf_mem[wr_ptr]);
                            buf_mem[wr_ptr] <= clamped;
                            wr_ptr          <= wr_ptr + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_distance_smoother.sv
// Directed self-checking bench for distance_smoother; expected values are hand-derived,
// with the slew rule applied on top when SMOOTH_SLEW_LIMIT_EN is defined.
module tb_distance_smoother;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        clear;
    logic        sample_valid;
    logic [12:0] sample_in;
    logic [12:0] distance_out;
    logic        distance_valid;

    int errors;
    int checks;
    int exp_out;
    int exp_avg;

    distance_smoother dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .clear          (clear),
        .sample_valid   (sample_valid),
        .sample_in      (sample_in),
        .distance_out   (distance_out),
        .distance_valid (distance_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int slewModel(input int prev, input int avg, input bit prime);
`ifdef SMOOTH_SLEW_LIMIT_EN
        if (prime) return avg;
        if (avg > prev + 8) return prev + 8;
        if (avg + 8 < prev) return prev - 8;
        return avg;
`else
        return avg;
`endif
    endfunction

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Presents one cycle of inputs, returns 1 time unit after the clock edge.
    task automatic applyStimulus(input logic en, input logic vld, input logic clr, input int s);
        enable       = en;
        sample_valid = vld;
        clear        = clr;
        sample_in    = 13'(s);
        @(posedge clk);
        #1;
        enable       = 1'b1;
        sample_valid = 1'b0;
        clear        = 1'b0;
        sample_in    = '0;
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        exp_out      = 0;
        reset_n      = 1'b0;
        enable       = 1'b0;
        clear        = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out", distance_out, 0);
        checkOutput("reset_valid", distance_valid, 0);
        reset_n = 1'b1;

        applyStimulus(1, 1, 0, 1000);
        applyStimulus(1, 0, 0, 0);
        checkOutput("prime_valid", distance_valid, 1);
        checkOutput("prime_out", distance_out, 1000);
        applyStimulus(1, 0, 0, 0);
        checkOutput("prime_strobe_len", distance_valid, 0);

        applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 1, 0, 3000);
        applyStimulus(1, 0, 0, 0);
        checkOutput("clamp_valid", distance_valid, 1);
        checkOutput("clamp_out", distance_out, 2000);

        applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 1, 0, 100);
        applyStimulus(1, 0, 0, 0);
        exp_out = 100;
        checkOutput("avg_prime", distance_out, exp_out);
        // Back-to-back samples: the strobe for sample k-1 is visible after sample k's edge.
        for (int k = 0; k <= 17; k++) begin
            if (k < 17) applyStimulus(1, 1, 0, 260);
            else        applyStimulus(1, 0, 0, 0);
            if (k > 0) begin
                exp_avg = 110 + 10 * (k - 1);
                if (exp_avg > 260) exp_avg = 260;
                exp_out = slewModel(exp_out, exp_avg, 1'b0);
                checkOutput($sformatf("avg_valid_%0d", k), distance_valid, 1);
                checkOutput($sformatf("avg_out_%0d", k), distance_out, exp_out);
            end
        end

        applyStimulus(1, 1, 1, 500);
        applyStimulus(1, 0, 0, 0);
        checkOutput("clear_prio_valid", distance_valid, 0);
        checkOutput("clear_prio_hold", distance_out, exp_out);
        applyStimulus(1, 1, 0, 700);
        applyStimulus(1, 0, 0, 0);
        exp_out = 700;
        checkOutput("reprime_valid", distance_valid, 1);
        checkOutput("reprime_out", distance_out, exp_out);

        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 0, 900);
            checkOutput($sformatf("gated_valid_%0d", k), distance_valid, 0);
            checkOutput($sformatf("gated_out_%0d", k), distance_out, exp_out);
        end

        applyStimulus(1, 1, 0, 1020);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("freeze_valid_%0d", k), distance_valid, 0);
        end
        applyStimulus(1, 0, 0, 0);
        exp_out = slewModel(exp_out, 720, 1'b0);
        checkOutput("resume_valid", distance_valid, 1);
        checkOutput("resume_out", distance_out, exp_out);

        applyStimulus(1, 1, 0, 1800);
        applyStimulus(1, 0, 1, 0);
        checkOutput("squash_valid_a", distance_valid, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("squash_valid_b", distance_valid, 0);
        checkOutput("squash_hold", distance_out, exp_out);
        applyStimulus(1, 1, 0, 1500);
        applyStimulus(1, 0, 0, 0);
        checkOutput("squash_reprime", distance_out, 1500);

        applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 1, 0, 100);
        applyStimulus(1, 0, 0, 0);
        checkOutput("slew_prime", distance_out, 100);
        applyStimulus(1, 1, 0, 2000);
        applyStimulus(1, 0, 0, 0);
        exp_out = slewModel(100, 218, 1'b0);
        checkOutput("slew_out", distance_out, exp_out);

        applyStimulus(1, 1, 0, 300);
        applyStimulus(1, 0, 0, 0);
        checkOutput("pre_reset_valid", distance_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_out", distance_out, 0);
        checkOutput("async_reset_valid", distance_valid, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(1, 1, 0, 50);
        applyStimulus(1, 0, 0, 0);
        checkOutput("post_reset_valid", distance_valid, 1);
        checkOutput("post_reset_prime", distance_out, 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
